// File: rtl/simon_round_ctrl.sv
// Simon round controller: owns the sequence-memory write/read ports, grows
// the pattern by one LFSR step per round, plays it back on the LEDs at the
// slow-tick cadence and then judges the player's presses against memory.
`timescale 1ns/1ps

module simon_round_ctrl #(
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned ON_TICKS      = 2,
    parameter int unsigned OFF_TICKS     = 1,
    parameter int unsigned TIMEOUT_TICKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic [1:0]        rnd,
    input  logic              btn_valid,
    input  logic [1:0]        btn_val,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic [3:0]        led,
    output logic              error_led,
    output logic              win,
    output logic [ADDR_W:0]   round_len,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPEND   = 3'd1,
        S_PLAY_ON  = 3'd2,
        S_PLAY_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_FAIL     = 3'd5,
        S_WIN      = 3'd6
    } state_t;

    localparam int unsigned    CNT_W    = 16;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [ADDR_W:0]  MAX_LEN_V = (ADDR_W + 1)'(MAX_LEN);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     round_len_q, round_len_d;
    logic [ADDR_W-1:0]   play_idx_q, play_idx_d;
    logic [ADDR_W-1:0]   in_idx_q, in_idx_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
    logic [3:0]          led_q, led_d;
    logic                error_q, error_d;
    logic                win_q, win_d;
    logic                first_q, first_d;
    logic [ADDR_W:0]     len_m1;
    logic [ADDR_W-1:0]   last_idx;

    function automatic logic [3:0] onehot(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    assign len_m1   = round_len_q - 1'b1;
    assign last_idx = len_m1[ADDR_W-1:0];

    // Memory ports and debug state decode straight from the state registers.
    assign wr_en     = (state_q == S_APPEND);
    assign wr_addr   = round_len_q[ADDR_W-1:0];
    assign wr_data   = rnd;
    assign rd_addr   = (state_q == S_INPUT) ? in_idx_q : play_idx_q;
    assign state     = state_q;
    assign led       = led_q;
    assign error_led = error_q;
    assign win       = win_q;
    assign round_len = round_len_q;

    // Next-state, index/counter updates and next values of registered outputs.
    always_comb begin
        state_d     = state_q;
        round_len_d = round_len_q;
        play_idx_d  = play_idx_q;
        in_idx_d    = in_idx_q;
        tick_cnt_d  = tick_cnt_q;
        to_cnt_d    = to_cnt_q;
        led_d       = '0;
        error_d     = 1'b0;
        win_d       = 1'b0;
        first_d     = 1'b0;

        case (state_q)
            S_IDLE, S_FAIL, S_WIN: begin
                if (start) begin
                    round_len_d = '0;
                    state_d     = S_APPEND;
                end
            end
            S_APPEND: begin
                round_len_d = round_len_q + 1'b1;
                play_idx_d  = '0;
                tick_cnt_d  = '0;
                state_d     = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (tick) begin
                    if (tick_cnt_q == ON_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = S_PLAY_OFF;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY_OFF: begin
                if (tick) begin
                    if (tick_cnt_q == OFF_LAST) begin
                        tick_cnt_d = '0;
                        if (play_idx_q == last_idx) begin
                            in_idx_d = '0;
                            to_cnt_d = '0;
                            state_d  = S_INPUT;
                        end else begin
                            play_idx_d = play_idx_q + 1'b1;
                            state_d    = S_PLAY_ON;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_INPUT: begin
                // A press outranks a coincident tick: the timeout restarts.
                if (btn_valid) begin
                    to_cnt_d = '0;
                    if (btn_val == rd_data) begin
                        if (in_idx_q == last_idx) begin
                            state_d = (round_len_q == MAX_LEN_V) ? S_WIN : S_APPEND;
                        end else begin
                            in_idx_d = in_idx_q + 1'b1;
                        end
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (tick) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // rd_data for the current step is only valid from the 2nd clk in
        // PLAY_ON, so the LED is loaded starting then and stays dark before.
        first_d = (state_d == S_PLAY_ON) && (state_q != S_PLAY_ON);
        case (state_d)
            S_PLAY_ON: if (state_q == S_PLAY_ON && !first_q) led_d = onehot(rd_data);
            S_WIN:     led_d = '1;
            default:   led_d = '0;
        endcase
        error_d = (state_d == S_FAIL);
        win_d   = (state_d == S_WIN);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Indices, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_len_q <= '0;
            play_idx_q  <= '0;
            in_idx_q    <= '0;
            tick_cnt_q  <= '0;
            to_cnt_q    <= '0;
            led_q       <= '0;
            error_q     <= 1'b0;
            win_q       <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            round_len_q <= round_len_d;
            play_idx_q  <= play_idx_d;
            in_idx_q    <= in_idx_d;
            tick_cnt_q  <= tick_cnt_d;
            to_cnt_q    <= to_cnt_d;
            led_q       <= led_d;
            error_q     <= error_d;
            win_q       <= win_d;
            first_q     <= first_d;
        end
    end

endmodule

// File: doc/simon_round_ctrl.md
# simon_round_ctrl

Round controller for the Simon game. It owns the 2-bit sequence memory and grows the pattern by one LFSR-supplied step per round. It plays the pattern back on the LEDs using the slow-tick cadence, then checks the player's presses against memory. It sits between the LFSR/button front end and the LED/debug outputs, and replaces the fixed-length hardcoded FSM.

## Interface
- `MAX_LEN`, default 16: winning pattern length; 1 ≤ MAX_LEN ≤ 2^ADDR_W.
- `ADDR_W`, default 4: sequence memory address width.
- `ON_TICKS`, default 2: ticks each step's LED is lit during playback (≥1).
- `OFF_TICKS`, default 1: dark ticks between playback steps (≥1).
- `TIMEOUT_TICKS`, default 8: ticks allowed between player presses before failure.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high; clears all state.
- `tick` in 1: one-clk enable pulse from the clock divider; consecutive pulses are ≥2 clk apart.
- `start` in 1: one-clk pulse that begins a new game.
- `rnd` in 2: LFSR value; sampled only in APPEND.
- `btn_valid` in 1: one-clk press pulse; consecutive pulses are ≥2 clk apart.
- `btn_val` in 2: pressed button index; valid with `btn_valid`.
- `wr_en` out 1, `wr_addr` out ADDR_W, `wr_data` out 2: sequence memory write port.
- `rd_addr` out ADDR_W: memory read address.
- `rd_data` in 2: memory read data, one clk after `rd_addr` (synchronous read).
- `led` out 4: one-hot LED drive.
- `error_led` out 1: high in FAIL.
- `win` out 1: high in WIN.
- `round_len` out ADDR_W+1: current pattern length.
- `state` out 3: FSM state code, used for the debug display.

## Operation
- State codes: IDLE=0, APPEND=1, PLAY_ON=2, PLAY_OFF=3, INPUT=4, FAIL=5, WIN=6. Code 7 is unused and recovers to IDLE.
- Reset values: state IDLE, `round_len`=0, all indices and counters 0, `led`=0, `wr_en`=0, `error_led`=0, `win`=0, `rd_addr`=0.
- IDLE / FAIL / WIN:
  - `start` clears `round_len` and goes to APPEND.
  - All other inputs are ignored.
  - `start` is ignored in every other state.
- APPEND (1 clk):
  - `wr_en`=1, `wr_addr`=`round_len`, `wr_data`=`rnd`.
  - `round_len`+=1, `play_idx`=0, tick counter=0, then PLAY_ON.
- PLAY_ON:
  - `rd_addr`=`play_idx`.
  - `led` is registered; it loads onehot(`rd_data`) on the 2nd clk in the state, so the 1st clk shows 0.
  - After ON_TICKS ticks, go to PLAY_OFF.
- PLAY_OFF:
  - `led`=0.
  - After OFF_TICKS ticks: if `play_idx`==`round_len`-1, go to INPUT with `in_idx`=0 and timeout counter 0. Otherwise `play_idx`+=1 and go to PLAY_ON.
- INPUT:
  - `rd_addr`=`in_idx`, `led`=0.
  - `btn_valid` with `btn_val`==`rd_data` (correct press) clears the timeout counter. Then:
    - if `in_idx`==`round_len`-1: go to WIN when `round_len`==MAX_LEN, else go to APPEND.
    - otherwise `in_idx`+=1.
  - `btn_valid` with a mismatch goes to FAIL.
  - Each tick with no press increments the timeout counter; reaching TIMEOUT_TICKS goes to FAIL.
- FAIL: `error_led`=1, `led`=0.
- WIN: `win`=1, `led`=4'b1111.
- `btn_valid` outside INPUT is ignored. `tick` outside the PLAY and INPUT states is ignored.

## Timing
- All outputs are registered except `rd_addr`, `wr_*` and `state`, which are decoded directly from state registers.
- `start` to `wr_en` high: 1 clk.
- `wr_en` pulse: exactly 1 clk per round.
- The tick counter counts only `tick` pulses. Each phase lasts exactly N ticks counted after entry.
- A press is judged on the clk it arrives; the state/index update is visible next clk. The new `rd_data` is valid one clk later; this is safe because presses are ≥2 clk apart.
- Simultaneous press and tick in INPUT: the press has priority and the timeout counter is cleared, not incremented.
- `reset` asserted mid-game: outputs reach reset values immediately (asynchronous). The first `start` after release begins at `round_len`=0.
- `round_len` never exceeds MAX_LEN.
- Index arithmetic is ADDR_W-bit. `round_len` is ADDR_W+1-bit so MAX_LEN=2^ADDR_W is representable.

## Test plan
- Reset, then `start` with `rnd`=2 → one `wr_en` pulse at addr 0 with data 2, `round_len`=1. PLAY_ON shows `led`=4'b0100 for 2 ticks, then 1 dark tick, then `state`=4.
- Round 1 correct press `btn_val`=2 → APPEND writes addr 1; playback shows both steps in address order.
- Wrong press in round 2 at `in_idx`=1 → `state`=5, `error_led`=1, `led`=0. A later `start` → `round_len`=1 and `error_led`=0.
- No press for 8 ticks in INPUT → FAIL on the 8th tick. A press arriving on the same clk as the 8th tick, and correct → no FAIL.
- MAX_LEN=4 with all rounds correct → `win`=1, `led`=4'b1111, `round_len`=4. `start` in PLAY_ON/INPUT is ignored.
- Reset asserted during PLAY_ON of round 3 → same clk: `led`=0, `state`=0, `round_len`=0.
